// File: rtl/order_pkg.sv
// Shared ranks, FSM encoding and default widths for the 3-way sorter unloader slice.
package order_pkg;

    localparam int unsigned DSIZE_DEF = 64;
    localparam int unsigned CNTW_DEF  = 16;

    localparam logic [1:0] RANK_MAX = 2'd0;
    localparam logic [1:0] RANK_MID = 2'd1;
    localparam logic [1:0] RANK_MIN = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/order_check_3.sv
// Combinational ordering check: flags a triple that is not non-increasing (unsigned).
module order_check_3
    import order_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF
) (
    input  logic [DSIZE-1:0] d0_i,
    input  logic [DSIZE-1:0] d1_i,
    input  logic [DSIZE-1:0] d2_i,
    output logic             bad_o
);

    always_comb begin
        bad_o = (d0_i < d1_i) || (d1_i < d2_i);
    end

endmodule

// File: rtl/order_1_3_unload.sv
// Parallel-to-serial unloader: one sorted triple in, three ranked words out on a valid/ready stream.
// Optional input-ordering check is built when ORDER_1_3_UNLOAD_CHECK_EN is defined.
module order_1_3_unload
    import order_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned CNTW  = CNTW_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] indata0,
    input  logic [DSIZE-1:0] indata1,
    input  logic [DSIZE-1:0] indata2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       out_rank,
    output logic             out_last,
    output logic [CNTW-1:0]  triple_cnt,
    output logic             order_err
);

    state_t           state_q, state_d;
    logic [DSIZE-1:0] buf_q [3];
    logic [1:0]       rank_q, rank_d;
    logic [CNTW-1:0]  cnt_q;
    logic             fire, last_fire, accept;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EMIT;
            EMIT: if (last_fire) state_d = accept ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is the only combinational path from an input (out_ready) to an output.
    always_comb begin
        out_valid = (state_q == EMIT);
        fire      = out_valid && out_ready;
        last_fire = fire && (rank_q == RANK_MIN);
        in_ready  = (state_q == IDLE) || last_fire;
        accept    = in_valid && in_ready;
        out_rank  = rank_q;
        out_last  = (rank_q == RANK_MIN);
        case (rank_q)
            RANK_MID: out_data = buf_q[1];
            RANK_MIN: out_data = buf_q[2];
            default:  out_data = buf_q[0];
        endcase
    end

    always_comb begin
        rank_d = rank_q;
        if (accept || last_fire) begin
            rank_d = RANK_MAX;
        end else if (fire) begin
            rank_d = rank_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            buf_q[2] <= '0;
            rank_q   <= RANK_MAX;
            cnt_q    <= '0;
        end else begin
            rank_q <= rank_d;
            if (accept) begin
                buf_q[0] <= indata0;
                buf_q[1] <= indata1;
                buf_q[2] <= indata2;
            end
            if (last_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign triple_cnt = cnt_q;

`ifdef ORDER_1_3_UNLOAD_CHECK_EN
    logic bad, err_q;

    order_check_3 #(.DSIZE(DSIZE)) u_check (
        .d0_i  (indata0),
        .d1_i  (indata1),
        .d2_i  (indata2),
        .bad_o (bad)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && bad) begin
            err_q <= 1'b1;
        end
    end

    assign order_err = err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
